// File: rtl/adder_serial_ctrl.sv
// -----------------------------------------------------------------------------
// adder_serial_ctrl
//   Word-level valid/ready front end for a bit-serial adder. Two W-bit operands
//   are accepted in IDLE, presented LSB-first to the serial adder one bit per
//   clock, the sum bits and the final carry are gathered into a W+1-bit result,
//   and the result is held until the consumer takes it.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   producer offers in_a_i / in_b_i
//   in_ready_o   block is idle and will take operands
//   in_a_i       operand A (unsigned, W bits)
//   in_b_i       operand B (unsigned, W bits)
//   out_valid_o  out_sum_o holds a finished result
//   out_ready_i  consumer takes out_sum_o
//   out_sum_o    in_a + in_b, bit W is the carry-out
//   ser_a_o      serial bit to adder input A
//   ser_b_o      serial bit to adder input B
//   ser_clr_o    clears the adder carry at the next rising edge
//   ser_o_i      serial sum bit returned by the adder
// -----------------------------------------------------------------------------
module adder_serial_ctrl #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_a_i,
    input  logic [W-1:0] in_b_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W:0]   out_sum_o,
    output logic         ser_a_o,
    output logic         ser_b_o,
    output logic         ser_clr_o,
    input  logic         ser_o_i
);

    localparam int unsigned     CNT_W    = $clog2(W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CARRY,
        ST_DONE
    } state_e;

    state_e           state_q,     state_d;
    logic [W-1:0]     a_sh_q,      a_sh_d;
    logic [W-1:0]     b_sh_q,      b_sh_d;
    logic [W-1:0]     acc_q,       acc_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [W:0]       sum_q,       sum_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             ser_clr_q,   ser_clr_d;

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    a_sh_d  = in_a_i;
                    b_sh_d  = in_b_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Sum bits enter at the top; after W shifts bit 0 holds the LSB.
                acc_d  = W'({ser_o_i, acc_q} >> 1);
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_CARRY;
                end
            end
            ST_CARRY: begin
                // Shift registers are empty here, so ser_o_i is the bare carry-out.
                sum_d   = {ser_o_i, acc_q};
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake/control outputs are registered copies of the next state decode.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        ser_clr_d   = (state_d == ST_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ser_clr_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            ser_clr_q   <= ser_clr_d;
        end
    end

    // Shift registers drain to zero by CARRY and stay zero in DONE/IDLE,
    // so their LSBs drive the serial inputs directly.
    assign ser_a_o     = a_sh_q[0];
    assign ser_b_o     = b_sh_q[0];
    assign ser_clr_o   = ser_clr_q;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_sum_o   = sum_q;

endmodule

// File: tb/tb_adder_serial_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adder_serial_ctrl
//   Bench for adder_serial_ctrl with a behavioural serial adder attached.
//   Directed scenarios followed by a randomized operand/stall stream checked
//   against plain a+b arithmetic and a handshake-level timing model.
// -----------------------------------------------------------------------------
module tb_adder_serial_ctrl;

    localparam int unsigned W = 8;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_a      = '0;
    logic [W-1:0] in_b      = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W:0]   out_sum;
    logic         ser_a;
    logic         ser_b;
    logic         ser_clr;
    logic         ser_o;
    logic         carry_q   = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];

    always #5 clk = ~clk;

    // Behavioural bit-serial adder
    assign ser_o = ser_a ^ ser_b ^ carry_q;
    always @(posedge clk) begin
        carry_q <= ser_clr ? 1'b0 : ((ser_a & ser_b) | (carry_q & (ser_a | ser_b)));
    end

    adder_serial_ctrl #(.W(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_a_i     (in_a),
        .in_b_i     (in_b),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_sum_o  (out_sum),
        .ser_a_o    (ser_a),
        .ser_b_o    (ser_b),
        .ser_clr_o  (ser_clr),
        .ser_o_i    (ser_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the accept edge.
    task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(n < 50), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
    endtask

    // Counts cycles from the accept negedge until out_valid rises.
    task automatic wait_out(input string tag, input logic [W:0] expv);
        int n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(W + 1));
        chk({tag, "_sum"}, 32'(out_sum), 32'(expv));
    endtask

    task automatic consume(input string tag, input logic [W:0] expv);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_rel_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_rel_hold"}, 32'(out_sum), 32'(expv));
    endtask

    // Stream of n operations. Model: one op outstanding at a time; accepted at
    // negedge c means out_valid is seen from negedge c+W+2 until consumed.
    task automatic run_stream(input int n, input bit rnd);
        int         cyc       = 0;
        int         done      = 0;
        int         issued    = 0;
        int         acc_cyc   = 0;
        int         last_done = -1;
        bit         busy      = 1'b0;
        bit         was_busy;
        bit         ready_now;
        logic [W:0] exp_sum   = '0;
        logic [W-1:0] a;
        logic [W-1:0] b;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        while (done < n && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            was_busy  = busy;
            ready_now = busy && ((cyc - acc_cyc) >= int'(W) + 2);
            chk("s_in_ready", 32'(in_ready), 32'(!busy));
            chk("s_out_valid", 32'(out_valid), 32'(ready_now));
            if (ready_now) chk("s_out_sum", 32'(out_sum), 32'(exp_sum));

            // Producer
            if (!was_busy && issued < n) begin
                if (!rnd || $urandom_range(0, 2) != 0) begin
                    if (rnd) begin
                        a = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
                        b = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
                    end else begin
                        a = qa[issued];
                        b = qb[issued];
                    end
                    in_a     = a;
                    in_b     = b;
                    in_valid = 1'b1;
                    busy     = 1'b1;
                    acc_cyc  = cyc;
                    exp_sum  = {1'b0, a} + {1'b0, b};
                    issued++;
                end else begin
                    in_valid = 1'b0;
                end
            end else if (!was_busy) begin
                in_valid = 1'b0;
            end else if (rnd) begin
                // Noise while busy must be ignored.
                in_valid = 1'($urandom_range(0, 1));
                in_a     = W'($urandom);
                in_b     = W'($urandom);
            end else begin
                in_valid = 1'b1;
            end

            // Consumer
            if (ready_now) begin
                if (!rnd || $urandom_range(0, 3) != 0) begin
                    out_ready = 1'b1;
                    busy      = 1'b0;
                    done++;
                    if (!rnd && last_done >= 0)
                        chk("s_spacing", 32'(cyc - last_done), 32'(W + 3));
                    last_done = cyc;
                end else begin
                    out_ready = 1'b0;
                end
            end else begin
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        chk("s_completed", 32'(done), 32'(n));
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] a_v;
        logic [W-1:0] b_v;

        // Reset values
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_ser_a", 32'(ser_a), 32'd0);
        chk("rst_ser_b", 32'(ser_b), 32'd0);
        chk("rst_ser_clr", 32'(ser_clr), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // 3 + 5 with serial bit sequence and exact latency
        a_v = 8'h03;
        b_v = 8'h05;
        out_ready = 1'b1;
        send_op(a_v, b_v);
        for (int i = 0; i < int'(W); i++) begin
            chk("t1_ser_a", 32'(ser_a), 32'(a_v[i]));
            chk("t1_ser_b", 32'(ser_b), 32'(b_v[i]));
            chk("t1_ser_clr", 32'(ser_clr), 32'd0);
            chk("t1_not_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        chk("t1_carry_ser_a", 32'(ser_a), 32'd0);
        chk("t1_carry_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_sum", 32'(out_sum), 32'h008);
        consume("t1", 9'h008);

        // Carry-out and no carry leakage between operations
        send_op(8'hFF, 8'h01);
        wait_out("t2a", 9'h100);
        consume("t2a", 9'h100);
        send_op(8'hFF, 8'hFF);
        wait_out("t2b", 9'h1FE);
        consume("t2b", 9'h1FE);

        // Consumer stall with ignored producer traffic
        send_op(8'h5A, 8'hA5);
        wait_out("t3", 9'h0FF);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            chk("t3_hold_valid", 32'(out_valid), 32'd1);
            chk("t3_hold_sum", 32'(out_sum), 32'h0FF);
            chk("t3_hold_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        consume("t3", 9'h0FF);
        @(negedge clk);
        chk("t3_still_idle", 32'(in_ready), 32'd1);

        // Reset in the middle of SHIFT
        send_op(8'h5A, 8'h3C);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_out_valid", 32'(out_valid), 32'd0);
        chk("t4_out_sum", 32'(out_sum), 32'd0);
        chk("t4_in_ready", 32'(in_ready), 32'd1);
        chk("t4_ser_clr", 32'(ser_clr), 32'd1);
        chk("t4_ser_a", 32'(ser_a), 32'd0);
        send_op(8'h10, 8'h20);
        wait_out("t4", 9'h030);
        consume("t4", 9'h030);

        // Back-to-back with both handshakes held high
        qa = '{8'h01, 8'h80};
        qb = '{8'h01, 8'h80};
        run_stream(2, 1'b0);

        // Random operands with random stalls and gaps
        run_stream(200, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
